// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit common-anode FND scan driver: digit count,
// blank patterns and the active-low g..a hex font.
package fnd_pkg;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam logic [3:0]  FND_ALL_OFF = 4'b1111;
    localparam logic [7:0]  SEG_OFF     = 8'hFF;

    localparam logic [6:0] FONT_0 = 7'h40;
    localparam logic [6:0] FONT_1 = 7'h79;
    localparam logic [6:0] FONT_2 = 7'h24;
    localparam logic [6:0] FONT_3 = 7'h30;
    localparam logic [6:0] FONT_4 = 7'h19;
    localparam logic [6:0] FONT_5 = 7'h12;
    localparam logic [6:0] FONT_6 = 7'h02;
    localparam logic [6:0] FONT_7 = 7'h78;
    localparam logic [6:0] FONT_8 = 7'h00;
    localparam logic [6:0] FONT_9 = 7'h10;
    localparam logic [6:0] FONT_A = 7'h08;
    localparam logic [6:0] FONT_B = 7'h03;
    localparam logic [6:0] FONT_C = 7'h46;
    localparam logic [6:0] FONT_D = 7'h21;
    localparam logic [6:0] FONT_E = 7'h06;
    localparam logic [6:0] FONT_F = 7'h0E;

    // Active-low one-hot enable for the selected digit.
    function automatic logic [3:0] digit_select_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/fnd_scan_driver_seg7_font.sv
// Combinational hex nibble to active-low 7-segment (g..a) decoder.
module seg7_font
    import fnd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Font lookup.
    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0:    o_seg = FONT_0;
            4'h1:    o_seg = FONT_1;
            4'h2:    o_seg = FONT_2;
            4'h3:    o_seg = FONT_3;
            4'h4:    o_seg = FONT_4;
            4'h5:    o_seg = FONT_5;
            4'h6:    o_seg = FONT_6;
            4'h7:    o_seg = FONT_7;
            4'h8:    o_seg = FONT_8;
            4'h9:    o_seg = FONT_9;
            4'hA:    o_seg = FONT_A;
            4'hB:    o_seg = FONT_B;
            4'hC:    o_seg = FONT_C;
            4'hD:    o_seg = FONT_D;
            4'hE:    o_seg = FONT_E;
            4'hF:    o_seg = FONT_F;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 4-digit FND driver with per-slot dead-time, per-frame value
// capture and blanking. Optional duty control: define FND_BRIGHTNESS_EN.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1_000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_blank,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
`ifdef FND_BRIGHTNESS_EN
    input  logic [2:0]  i_brightness,
`endif
    output logic [3:0]  o_digitPosition,
    output logic [7:0]  o_fndFont
);

    localparam int unsigned TICK_MAX  = CLK_HZ / SCAN_HZ;
    localparam int unsigned TW        = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX - 1);
    localparam int unsigned DUTY_STEP = (TICK_MAX - GUARD_CYCLES) / 8;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_digits_q, shadow_digits_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic          first_q, first_d;
    logic [3:0]    pos_q, pos_d;
    logic [7:0]    font_q, font_d;
    logic [3:0]    nibble_s;
    logic [6:0]    seg_s;
    logic          wrap_s;
    logic          capture_s;
    logic          lit_s;
    logic [31:0]   tick_ext_s;
`ifdef FND_BRIGHTNESS_EN
    logic [2:0]    bright_q, bright_d;
    logic [31:0]   lit_end_s;
`endif

    assign nibble_s = shadow_digits_q[{idx_q, 2'b00} +: 4];

    seg7_font u_font (
        .i_nibble (nibble_s),
        .o_seg    (seg_s)
    );

    // Scan counters, frame capture and next output pattern.
    always_comb begin
        tick_cnt_d      = tick_cnt_q;
        idx_d           = idx_q;
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        first_d         = 1'b0;
        pos_d           = FND_ALL_OFF;
        font_d          = SEG_OFF;
        tick_ext_s      = 32'(tick_cnt_q);

        wrap_s = (tick_cnt_q == TICK_LAST);
        if (wrap_s) begin
            tick_cnt_d = {TW{1'b0}};
            idx_d      = idx_q + 2'd1;
        end else begin
            tick_cnt_d = tick_cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end

        // First clock after reset also captures so the first frame is valid.
        capture_s = first_q | (wrap_s & (idx_q == 2'd3));
        if (capture_s) begin
            shadow_digits_d = i_digits;
            shadow_dp_d     = i_dp;
        end else begin
            shadow_digits_d = shadow_digits_q;
            shadow_dp_d     = shadow_dp_q;
        end

`ifdef FND_BRIGHTNESS_EN
        bright_d  = capture_s ? i_brightness : bright_q;
        lit_end_s = 32'(GUARD_CYCLES) + (32'(bright_q) + 32'd1) * 32'(DUTY_STEP);
        if (lit_end_s > 32'(TICK_MAX)) begin
            lit_end_s = 32'(TICK_MAX);
        end else begin
            lit_end_s = lit_end_s;
        end
        lit_s = ~i_blank & (tick_ext_s >= 32'(GUARD_CYCLES)) & (tick_ext_s < lit_end_s);
`else
        lit_s = ~i_blank & (tick_ext_s >= 32'(GUARD_CYCLES));
`endif

        if (lit_s) begin
            pos_d  = digit_select_n(idx_q);
            font_d = {~shadow_dp_q[idx_q], seg_s};
        end else begin
            pos_d  = FND_ALL_OFF;
            font_d = SEG_OFF;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick_cnt_q      <= {TW{1'b0}};
            idx_q           <= 2'd0;
            shadow_digits_q <= 16'h0000;
            shadow_dp_q     <= 4'h0;
            first_q         <= 1'b1;
            pos_q           <= FND_ALL_OFF;
            font_q          <= SEG_OFF;
`ifdef FND_BRIGHTNESS_EN
            bright_q        <= 3'd0;
`endif
        end else begin
            tick_cnt_q      <= tick_cnt_d;
            idx_q           <= idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            first_q         <= first_d;
            pos_q           <= pos_d;
            font_q          <= font_d;
`ifdef FND_BRIGHTNESS_EN
            bright_q        <= bright_d;
`endif
        end
    end

    assign o_digitPosition = pos_q;
    assign o_fndFont       = font_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: TICK_MAX=10, GUARD_CYCLES=2, 40-clock frame.
module tb_fnd_scan_driver;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_blank;
    logic [15:0] i_digits;
    logic [3:0]  i_dp;
    logic [2:0]  i_brightness;
    logic [3:0]  o_digitPosition;
    logic [7:0]  o_fndFont;

    int          checks = 0;
    int          fails  = 0;
    int          t      = 0;
    int          lit_end = 10;
    logic        blank_exp = 1'b0;
    logic [7:0]  exp_font [4];

    always #5 clk = ~clk;

    fnd_scan_driver #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .GUARD_CYCLES (2)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_blank         (i_blank),
        .i_digits        (i_digits),
        .i_dp            (i_dp),
`ifdef FND_BRIGHTNESS_EN
        .i_brightness    (i_brightness),
`endif
        .o_digitPosition (o_digitPosition),
        .o_fndFont       (o_fndFont)
    );

    task automatic check(input string tag, input logic [3:0] ep, input logic [7:0] ef);
        checks++;
        assert (o_digitPosition === ep) else begin
            fails++;
            $error("FAIL %s t=%0d digitPosition got %b expected %b", tag, t, o_digitPosition, ep);
        end
        checks++;
        assert (o_fndFont === ef) else begin
            fails++;
            $error("FAIL %s t=%0d fndFont got %h expected %h", tag, t, o_fndFont, ef);
        end
    endtask

    // One clock in reset; outputs must be dark.
    task automatic rst_step(input string tag);
        @(posedge clk);
        #1;
        check(tag, 4'b1111, 8'hFF);
    endtask

    // One scan clock; expected pattern derived from clocks since release.
    task automatic step(input string tag);
        int ph;
        int ix;
        logic [3:0] ep;
        logic [7:0] ef;
        @(posedge clk);
        #1;
        t++;
        ph = (t - 1) % 10;
        ix = ((t - 1) / 10) % 4;
        if (blank_exp || ph < 2 || ph >= lit_end) begin
            ep = 4'b1111;
            ef = 8'hFF;
        end else begin
            ep = ~(4'b0001 << ix);
            ef = exp_font[ix];
        end
        check(tag, ep, ef);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_blank      = 1'b0;
        i_digits     = 16'h0000;
        i_dp         = 4'h0;
        i_brightness = 3'd7;

        repeat (3) rst_step("reset_hold");

        // Frame 0: 1234, digit 0 lit first.
        i_digits = 16'h1234;
        i_dp     = 4'b0000;
        i_reset  = 1'b0;
        exp_font[0] = 8'h99;
        exp_font[1] = 8'hB0;
        exp_font[2] = 8'hA4;
        exp_font[3] = 8'hF9;
        repeat (2) step("first_guard");
        step("first_lit");
        repeat (37) step("scan_1234");

        // Frame 1: change inputs while idx=1; display must stay on 1234.
        repeat (12) step("coherent_pre");
        i_digits = 16'hABCD;
        repeat (28) step("coherent_hold");

        // Frame 2: ABCD captured at the frame boundary.
        exp_font[0] = 8'hA1;
        exp_font[1] = 8'hC6;
        exp_font[2] = 8'h83;
        exp_font[3] = 8'h88;
        repeat (20) step("scan_abcd");
        i_digits = 16'h8888;
        i_dp     = 4'b0101;
        repeat (20) step("scan_abcd_hold");

        // Frame 3: decimal points.
        exp_font[0] = 8'h00;
        exp_font[1] = 8'h80;
        exp_font[2] = 8'h00;
        exp_font[3] = 8'h80;
        repeat (40) step("scan_dp");

        // Frame 4: blank for 15 clocks starting at tick_cnt=5 of digit 0.
        repeat (5) step("pre_blank");
        i_blank   = 1'b1;
        blank_exp = 1'b1;
        repeat (15) step("blank");
        i_blank   = 1'b0;
        blank_exp = 1'b0;
        repeat (20) step("post_blank");

        // Reset mid-scan, then restart at digit 0 with new value.
        repeat (4) step("pre_reset");
        i_reset  = 1'b1;
        i_digits = 16'hE9F0;
        i_dp     = 4'b1000;
        rst_step("reset_mid");
        i_reset  = 1'b0;
        t        = 0;
        exp_font[0] = 8'hC0;
        exp_font[1] = 8'h8E;
        exp_font[2] = 8'h90;
        exp_font[3] = 8'h06;
        step("restart");
`ifdef FND_BRIGHTNESS_EN
        i_brightness = 3'd3;
`endif
        repeat (39) step("restart_scan");
`ifdef FND_BRIGHTNESS_EN
        lit_end = 6;
`endif
        repeat (40) step("duty_frame");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
